// File: rtl/omp_fb_pkg.sv
// Shared constants and types for the OMP frame buffer capture stage.
package omp_fb_pkg;

    localparam int N_PIX      = 64;
    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 24;
    localparam int GRAY_SHIFT = 12;

    localparam logic signed [DATA_W-1:0] GRAY_MAX = DATA_W'(255);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        READOUT
    } fb_state_t;

endpackage

// File: rtl/omp_frame_buffer_if.sv
// Valid/ready pixel stream from the frame buffer to the display/UART path.
interface omp_frame_buffer_if;
    import omp_fb_pkg::*;

    logic [DATA_W-1:0] m_data;
    logic [ADDR_W-1:0] m_addr;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    modport master (
        output m_data,
        output m_addr,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_addr,
        input  m_valid,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/omp_fb_gray8.sv
// Converts a signed fixed-point pixel into an 8-bit gray level by an
// arithmetic right shift followed by a clamp to 0..255.
module omp_fb_gray8
    import omp_fb_pkg::*;
(
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic signed [DATA_W-1:0] shifted;

    assign shifted = $signed(din) >>> GRAY_SHIFT;

    // Clamp the shifted value: negatives go black, anything above full scale goes white.
    always_comb begin
        dout = '0;
        if (shifted[DATA_W-1]) begin
            dout = '0;
        end else if (shifted > GRAY_MAX) begin
            dout[7:0] = 8'hFF;
        end else begin
            dout[7:0] = shifted[7:0];
        end
    end

endmodule

// File: rtl/omp_frame_buffer.sv
// Capture stage for the OMP reconstruction core. Collects the sparse pixel
// write stream into an 8x8 flop buffer (unwritten pixels read as zero) and,
// once reconstruction is done, streams all 64 pixels in raster order.
// Optional build macro: OMP_FB_GRAY8_EN converts each streamed pixel to an
// 8-bit gray level instead of the raw 24-bit value.
module omp_frame_buffer
    import omp_fb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic [DATA_W-1:0]  pixel_val,
    input  logic [ADDR_W-1:0]  pixel_addr,
    input  logic               pixel_we,
    input  logic               done_all,
    omp_frame_buffer_if.master m_if,
    output logic               busy,
    output logic [ADDR_W:0]    pix_count,
    output logic               wr_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

    fb_state_t state;
    fb_state_t state_next;

    logic [DATA_W-1:0] mem [N_PIX];
    logic [N_PIX-1:0]  bitmap;

    // One extra bit marks that every pixel has already been loaded.
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W-1:0] rd_idx;
    logic [DATA_W-1:0] rd_raw;
    logic [DATA_W-1:0] rd_data;

    logic [DATA_W-1:0] m_data_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic              m_valid_q;
    logic              m_last_q;

    logic wr_fire;
    logic err_set;
    logic rd_load;
    logic rd_start;
    logic handshake;

    assign handshake = m_valid_q && m_if.m_ready;
    assign rd_idx    = rd_ptr[ADDR_W-1:0];
    assign rd_raw    = bitmap[rd_idx] ? mem[rd_idx] : '0;

`ifdef OMP_FB_GRAY8_EN
    omp_fb_gray8 u_gray8 (
        .din  (rd_raw),
        .dout (rd_data)
    );
`else
    assign rd_data = rd_raw;
`endif

    assign m_if.m_data  = m_data_q;
    assign m_if.m_addr  = m_addr_q;
    assign m_if.m_valid = m_valid_q;
    assign m_if.m_last  = m_last_q;

    // Next-state and per-cycle control decode; frame_start overrides everything.
    always_comb begin
        state_next = state;
        wr_fire    = 1'b0;
        err_set    = 1'b0;
        rd_load    = 1'b0;
        rd_start   = 1'b0;
        if (frame_start) begin
            state_next = CAPTURE;
        end else begin
            case (state)
                IDLE: begin
                    err_set = pixel_we;
                end
                CAPTURE: begin
                    wr_fire = pixel_we;
                    if (done_all) begin
                        state_next = READOUT;
                        rd_start   = 1'b1;
                    end
                end
                READOUT: begin
                    err_set = pixel_we;
                    rd_load = !rd_ptr[ADDR_W] && (!m_valid_q || m_if.m_ready);
                    if (handshake && m_last_q) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State register, with busy registered alongside it as a decode of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    // Pixel storage has no reset; the written bitmap masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[pixel_addr] <= pixel_val;
        end
    end

    // Track which addresses were written this frame, the distinct count and stray writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap    <= '0;
            pix_count <= '0;
            wr_err    <= 1'b0;
        end else if (frame_start) begin
            bitmap    <= '0;
            pix_count <= '0;
            wr_err    <= 1'b0;
        end else begin
            if (wr_fire) begin
                bitmap[pixel_addr] <= 1'b1;
                if (!bitmap[pixel_addr]) begin
                    pix_count <= pix_count + (ADDR_W+1)'(1);
                end
            end
            if (err_set) begin
                wr_err <= 1'b1;
            end
        end
    end

    // Output register: loads the next pixel whenever the slot is empty or being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            m_data_q  <= '0;
            m_addr_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else if (frame_start) begin
            rd_ptr    <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else if (rd_start) begin
            rd_ptr <= '0;
        end else if (rd_load) begin
            m_data_q  <= rd_data;
            m_addr_q  <= rd_idx;
            m_last_q  <= (rd_idx == LAST_ADDR);
            m_valid_q <= 1'b1;
            rd_ptr    <= rd_ptr + (ADDR_W+1)'(1);
        end else if (handshake) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_omp_frame_buffer.sv
// Self-checking bench for omp_frame_buffer: a reference model of the frame
// fills a queue of expected beats and a negedge monitor pops and compares them.
module tb_omp_frame_buffer;
    import omp_fb_pkg::*;

    typedef struct packed {
        logic [23:0] data;
        logic [5:0]  addr;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [23:0] pixel_val = '0;
    logic [5:0]  pixel_addr = '0;
    logic        pixel_we = 1'b0;
    logic        done_all = 1'b0;
    logic        busy;
    logic [6:0]  pix_count;
    logic        wr_err;

    omp_frame_buffer_if bus();

    omp_frame_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pixel_val   (pixel_val),
        .pixel_addr  (pixel_addr),
        .pixel_we    (pixel_we),
        .done_all    (done_all),
        .m_if        (bus),
        .busy        (busy),
        .pix_count   (pix_count),
        .wr_err      (wr_err)
    );

    always #5 clk = ~clk;

    int    vectors = 0;
    int    miscompares = 0;
    beat_t exp_q[$];

    logic [23:0] model_mem [64];
    logic        model_bm [64];
    int          model_cnt = 0;
    logic        model_err = 1'b0;

    int cyc_cnt = 0;
    int first_cyc = 0;
    int last_cyc = 0;

    bit    stall_prev = 1'b0;
    beat_t held;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Scoreboard monitor: compares accepted beats and checks stability while stalled.
    always @(negedge clk) begin
        beat_t got;
        beat_t expd;
        got = {bus.m_data, bus.m_addr, bus.m_last};
        if (stall_prev) begin
            vectors++;
            if (!bus.m_valid || got !== held) begin
                miscompares++;
                $display("[TB] FAIL stall_hold: got valid=%0b beat=%h, expected valid=1 beat=%h",
                         bus.m_valid, got, held);
            end
        end
        stall_prev = 1'b0;
        if (rst_n && bus.m_valid && !frame_start) begin
            if (bus.m_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_beat: got addr=%0d data=%h, expected no beat",
                             bus.m_addr, bus.m_data);
                end else begin
                    expd = exp_q.pop_front();
                    if (got !== expd) begin
                        miscompares++;
                        $display("[TB] FAIL beat: got data=%h addr=%0d last=%0b, expected data=%h addr=%0d last=%0b",
                                 got.data, got.addr, got.last, expd.data, expd.addr, expd.last);
                    end
                    if (got.addr == 6'd0)  first_cyc = cyc_cnt;
                    if (got.addr == 6'd63) last_cyc = cyc_cnt;
                end
            end else begin
                stall_prev = 1'b1;
                held = got;
            end
        end
    end

    function automatic logic [23:0] exp_pix(input logic [23:0] v);
`ifdef OMP_FB_GRAY8_EN
        int s;
        s = int'($signed(v)) >>> 12;
        if (s < 0) return 24'd0;
        if (s > 255) return 24'd255;
        return 24'(s);
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model_bm[i] = 1'b0;
        model_cnt = 0;
        model_err = 1'b0;
    endtask

    task automatic push_frame();
        beat_t b;
        for (int i = 0; i < 64; i++) begin
            b.data = model_bm[i] ? exp_pix(model_mem[i]) : 24'h0;
            b.addr = 6'(i);
            b.last = (i == 63);
            exp_q.push_back(b);
        end
    endtask

    task automatic start_frame(input bit with_we, input logic [5:0] a, input logic [23:0] v);
        frame_start = 1'b1;
        pixel_we    = with_we;
        pixel_addr  = a;
        pixel_val   = v;
        tick();
        frame_start = 1'b0;
        pixel_we    = 1'b0;
        model_clear();
    endtask

    task automatic write_pix(input logic [5:0] a, input logic [23:0] v, input bit with_done);
        pixel_we   = 1'b1;
        pixel_addr = a;
        pixel_val  = v;
        done_all   = with_done;
        tick();
        pixel_we = 1'b0;
        done_all = 1'b0;
        if (!model_bm[a]) model_cnt++;
        model_bm[a]  = 1'b1;
        model_mem[a] = v;
        if (with_done) push_frame();
    endtask

    task automatic stray_write(input logic [5:0] a, input logic [23:0] v);
        pixel_we   = 1'b1;
        pixel_addr = a;
        pixel_val  = v;
        tick();
        pixel_we  = 1'b0;
        model_err = 1'b1;
    endtask

    task automatic finish_frame();
        done_all = 1'b1;
        tick();
        done_all = 1'b0;
        push_frame();
    endtask

    task automatic run_readout(input bit toggle);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            bus.m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            tick();
            cyc++;
        end
        bus.m_ready = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL readout_timeout: got %0d beats outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.m_valid, bus.m_last, busy, wr_err} !== 4'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b, expected 0000", {bus.m_valid, bus.m_last, busy, wr_err});
        end
        vectors++;
        if ({bus.m_data, bus.m_addr, pix_count} !== 37'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got data=%h addr=%0d count=%0d, expected 0/0/0",
                     bus.m_data, bus.m_addr, pix_count);
        end
        rst_n = 1'b1;
        tick();
        model_clear();
    endtask

    task automatic test_capture();
        $display("[TB] test_capture");
        start_frame(1'b0, 6'd0, 24'h0);
        write_pix(6'd5, 24'h0A3000, 1'b0);
        write_pix(6'd63, 24'h012345, 1'b1);
        vectors++;
        if ({bus.m_valid, busy} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL done_latency_t: got valid=%0b busy=%0b, expected valid=0 busy=1", bus.m_valid, busy);
        end
        vectors++;
        if (pix_count !== 7'd2) begin
            miscompares++;
            $display("[TB] FAIL capture_count: got %0d, expected 2", pix_count);
        end
        bus.m_ready = 1'b0;
        tick();
        vectors++;
        if (bus.m_valid !== 1'b1 || bus.m_addr !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL done_latency_t1: got valid=%0b addr=%0d, expected valid=1 addr=0", bus.m_valid, bus.m_addr);
        end
        run_readout(1'b0);
        vectors++;
        if (last_cyc - first_cyc !== 63) begin
            miscompares++;
            $display("[TB] FAIL throughput: got span %0d cycles, expected 63", last_cyc - first_cyc);
        end
        vectors++;
        if ({bus.m_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL readout_end: got valid=%0b busy=%0b, expected 0/0", bus.m_valid, busy);
        end
    endtask

    task automatic test_duplicate();
        $display("[TB] test_duplicate");
        start_frame(1'b0, 6'd0, 24'h0);
        write_pix(6'd7, 24'h000100, 1'b0);
        write_pix(6'd7, 24'h000200, 1'b0);
        vectors++;
        if (pix_count !== 7'(model_cnt)) begin
            miscompares++;
            $display("[TB] FAIL duplicate_count: got %0d, expected %0d", pix_count, model_cnt);
        end
        finish_frame();
        run_readout(1'b0);
    endtask

    task automatic test_backpressure();
        $display("[TB] test_backpressure");
        start_frame(1'b0, 6'd0, 24'h0);
        for (int i = 0; i < 8; i++) begin
            write_pix(6'($urandom_range(63)), 24'($urandom), 1'b0);
        end
        finish_frame();
        run_readout(1'b1);
        vectors++;
        if (pix_count !== 7'(model_cnt) || bus.m_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL backpressure_end: got count=%0d valid=%0b, expected count=%0d valid=0",
                     pix_count, bus.m_valid, model_cnt);
        end
    endtask

    task automatic test_gray8();
        $display("[TB] test_gray8");
        start_frame(1'b0, 6'd0, 24'h0);
        write_pix(6'd10, 24'h0A3000, 1'b0);
        write_pix(6'd11, 24'h800000, 1'b0);
        write_pix(6'd12, 24'h7FFFFF, 1'b0);
        finish_frame();
        run_readout(1'b0);
    endtask

    task automatic test_abort();
        int cyc = 0;
        $display("[TB] test_abort");
        start_frame(1'b0, 6'd0, 24'h0);
        write_pix(6'd20, 24'h0ABCDE, 1'b0);
        write_pix(6'd30, 24'h000001, 1'b0);
        finish_frame();
        bus.m_ready = 1'b1;
        while (!(bus.m_valid && bus.m_addr == 6'd20) && cyc < 200) begin
            tick();
            cyc++;
        end
        vectors++;
        if (!(bus.m_valid && bus.m_addr == 6'd20)) begin
            miscompares++;
            $display("[TB] FAIL abort_reach_beat20: got valid=%0b addr=%0d, expected valid=1 addr=20",
                     bus.m_valid, bus.m_addr);
        end
        bus.m_ready = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        exp_q.delete();
        model_clear();
        vectors++;
        if ({bus.m_valid, busy, pix_count} !== {1'b0, 1'b1, 7'd0}) begin
            miscompares++;
            $display("[TB] FAIL abort_drop: got valid=%0b busy=%0b count=%0d, expected 0/1/0",
                     bus.m_valid, busy, pix_count);
        end
        finish_frame();
        run_readout(1'b0);
        vectors++;
        if (pix_count !== 7'd0) begin
            miscompares++;
            $display("[TB] FAIL empty_frame_count: got %0d, expected 0", pix_count);
        end
    endtask

    task automatic test_start_write_collision();
        $display("[TB] test_start_write_collision");
        start_frame(1'b1, 6'd9, 24'h777777);
        vectors++;
        if ({pix_count, wr_err} !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL collision_state: got count=%0d err=%0b, expected 0/0", pix_count, wr_err);
        end
        finish_frame();
        run_readout(1'b0);
    endtask

    task automatic test_wr_err();
        $display("[TB] test_wr_err");
        stray_write(6'd3, 24'h000BAD);
        vectors++;
        if (wr_err !== model_err || pix_count !== 7'(model_cnt)) begin
            miscompares++;
            $display("[TB] FAIL idle_write: got err=%0b count=%0d, expected err=%0b count=%0d",
                     wr_err, pix_count, model_err, model_cnt);
        end
        start_frame(1'b0, 6'd0, 24'h0);
        vectors++;
        if (wr_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL err_clear_1: got %0b, expected 0", wr_err);
        end
        write_pix(6'd3, 24'h000111, 1'b0);
        finish_frame();
        stray_write(6'd3, 24'hBADBAD);
        stray_write(6'd4, 24'hBADBAD);
        vectors++;
        if (wr_err !== 1'b1 || pix_count !== 7'd1) begin
            miscompares++;
            $display("[TB] FAIL readout_write: got err=%0b count=%0d, expected err=1 count=1", wr_err, pix_count);
        end
        run_readout(1'b0);
        start_frame(1'b0, 6'd0, 24'h0);
        vectors++;
        if (wr_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL err_clear_2: got %0b, expected 0", wr_err);
        end
        finish_frame();
        run_readout(1'b0);
    endtask

    task automatic test_reset_midframe();
        $display("[TB] test_reset_midframe");
        start_frame(1'b0, 6'd0, 24'h0);
        write_pix(6'd2, 24'h000055, 1'b0);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.m_valid, busy, wr_err, pix_count} !== 10'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got valid=%0b busy=%0b err=%0b count=%0d, expected all 0",
                     bus.m_valid, busy, wr_err, pix_count);
        end
        model_clear();
        tick();
        rst_n = 1'b1;
        tick();
        start_frame(1'b0, 6'd0, 24'h0);
        finish_frame();
        run_readout(1'b0);
    endtask

    initial begin
        bus.m_ready = 1'b0;
        test_reset();
        test_capture();
        test_duplicate();
        test_backpressure();
        test_gray8();
        test_abort();
        test_start_write_collision();
        test_wr_err();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
